// File: rtl/usb_sync_fifo_if.sv
// FT232H/FT60x-style synchronous FIFO bridge: RX/TX word buffers
// behind a burst-arbitrated, round-robin bus state machine.
module usb_sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RX_DEPTH   = 512,
    parameter int TX_DEPTH   = 512,
    parameter int BURST_MAX  = 64,
    parameter int SKID       = 3
) (
    input  logic                      usb_clk_60m,
    input  logic                      sys_rst_n,
    input  logic                      usb_rxf_n,
    input  logic                      usb_txe_n,
    output logic                      usb_oe_n,
    output logic                      usb_rd_n,
    output logic                      usb_wr_n,
    inout  wire  [DATA_WIDTH-1:0]     usb_data,
    output logic [DATA_WIDTH-1:0]     rx_tdata,
    output logic                      rx_tvalid,
    input  logic                      rx_tready,
    input  logic [DATA_WIDTH-1:0]     tx_tdata,
    input  logic                      tx_tvalid,
    output logic                      tx_tready,
    output logic [$clog2(RX_DEPTH):0] rx_level,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic [31:0]               rx_word_cnt,
    output logic [31:0]               tx_word_cnt
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL    = (RAW+1)'(RX_DEPTH);
    localparam logic [RAW:0] RX_LIM     = (RAW+1)'(RX_DEPTH - SKID);
    localparam logic [TAW:0] TX_FULL    = (TAW+1)'(TX_DEPTH);
    localparam logic [7:0]   BURST_LAST = 8'(BURST_MAX - 1);

    typedef enum logic [2:0] {IDLE, RD_OE, RD, WR, TURN} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [RAW-1:0]        rx_wp, rx_rp;
    logic [TAW-1:0]        tx_wp, tx_rp;
    logic [7:0]            burst_cnt;
    logic                  prefer_rd;
    logic                  rx_cap, rx_push, rx_pop;
    logic                  tx_push, tx_pop;
    logic                  rd_ok, wr_ok, xfer, burst_end;
    logic [RAW:0]          rx_level_nxt;
    logic [TAW:0]          tx_level_nxt;

    // A capture while full is a margin violation and is dropped.
    assign rx_cap    = !usb_rd_n && !usb_rxf_n;
    assign rx_push   = rx_cap && (rx_level != RX_FULL);
    assign rx_pop    = rx_tvalid && rx_tready;
    assign tx_pop    = !usb_wr_n && !usb_txe_n && (tx_level != '0);
    assign tx_push   = tx_tvalid && tx_tready;
    assign rx_tvalid = (rx_level != '0);
    assign tx_tready = (tx_level != TX_FULL);
    assign rx_tdata  = rx_mem[rx_rp];

    assign rx_level_nxt = rx_level + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
    assign tx_level_nxt = tx_level + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);

    assign rd_ok     = !usb_rxf_n && (rx_level < RX_LIM);
    assign wr_ok     = !usb_txe_n && (tx_level != '0);
    assign xfer      = (state == RD) ? rx_cap : tx_pop;
    assign burst_end = xfer && (burst_cnt == BURST_LAST);

    // Bus ownership follows the registered state, so reset releases it at once.
    assign usb_data = (state == WR) ? tx_mem[tx_rp] : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (rd_ok && (!wr_ok || prefer_rd))
                    state_nxt = RD_OE;
                else if (wr_ok)
                    state_nxt = WR;
            end
            RD_OE: state_nxt = RD;
            RD: begin
                if (usb_rxf_n || (rx_level_nxt >= RX_LIM) || burst_end)
                    state_nxt = TURN;
            end
            WR: begin
                if (usb_txe_n || (tx_level_nxt == '0) || burst_end)
                    state_nxt = TURN;
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            usb_oe_n  <= 1'b1;
            usb_rd_n  <= 1'b1;
            usb_wr_n  <= 1'b1;
            prefer_rd <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            usb_oe_n  <= !((state_nxt == RD_OE) || (state_nxt == RD));
            usb_rd_n  <= (state_nxt != RD);
            usb_wr_n  <= (state_nxt != WR);
            if ((state == IDLE) && (state_nxt == RD_OE))
                prefer_rd <= 1'b0;
            else if ((state == IDLE) && (state_nxt == WR))
                prefer_rd <= 1'b1;
            if ((state != RD) && (state != WR))
                burst_cnt <= '0;
            else if (xfer)
                burst_cnt <= burst_cnt + 8'd1;
        end
    end

    always_ff @(posedge usb_clk_60m) begin
        if (rx_push)
            rx_mem[rx_wp] <= usb_data;
        if (tx_push)
            tx_mem[tx_wp] <= tx_tdata;
    end

    always_ff @(posedge usb_clk_60m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            tx_wp       <= '0;
            tx_rp       <= '0;
            rx_level    <= '0;
            tx_level    <= '0;
            rx_word_cnt <= '0;
            tx_word_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_wp       <= rx_wp + 1'b1;
                rx_word_cnt <= rx_word_cnt + 32'd1;
            end
            if (rx_pop)
                rx_rp <= rx_rp + 1'b1;
            if (tx_push)
                tx_wp <= tx_wp + 1'b1;
            if (tx_pop) begin
                tx_rp       <= tx_rp + 1'b1;
                tx_word_cnt <= tx_word_cnt + 32'd1;
            end
            rx_level <= rx_level_nxt;
            tx_level <= tx_level_nxt;
        end
    end
endmodule

// File: tb/tb_usb_sync_fifo_if.sv
// Directed bench for usb_sync_fifo_if: TX fill table plus
// hand-written RX/TX/arbitration/reset sequences.
module tb_usb_sync_fifo_if;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rxf_block = 1'b1;
    logic       txe_n = 1'b1;
    logic       rx_tready = 1'b0;
    logic [7:0] tx_tdata = 8'h00;
    logic       tx_tvalid = 1'b0;

    wire        usb_rxf_n;
    wire        usb_oe_n, usb_rd_n, usb_wr_n;
    wire  [7:0] usb_data;
    logic [7:0] rx_tdata;
    logic       rx_tvalid, tx_tready;
    logic [4:0] rx_level, tx_level;
    logic [31:0] rx_word_cnt, tx_word_cnt;

    logic [7:0] src_mem [256];
    int         src_idx = 0;
    int         src_n = 0;

    logic [7:0] rx_q[$];
    logic [7:0] host_q[$];
    bit         dir_q[$];
    int         contention = 0;
    int         oe_cnt = 0;
    int         oe_err = 0;
    logic       prev_oe_only = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign usb_rxf_n = rxf_block || (src_idx >= src_n);
    assign usb_data  = !usb_oe_n ? src_mem[src_idx[7:0]] : 8'bz;

    usb_sync_fifo_if #(
        .DATA_WIDTH(8), .RX_DEPTH(16), .TX_DEPTH(16),
        .BURST_MAX(4), .SKID(3)
    ) dut (
        .usb_clk_60m(clk),
        .sys_rst_n(rst_n),
        .usb_rxf_n(usb_rxf_n),
        .usb_txe_n(txe_n),
        .usb_oe_n(usb_oe_n),
        .usb_rd_n(usb_rd_n),
        .usb_wr_n(usb_wr_n),
        .usb_data(usb_data),
        .rx_tdata(rx_tdata),
        .rx_tvalid(rx_tvalid),
        .rx_tready(rx_tready),
        .tx_tdata(tx_tdata),
        .tx_tvalid(tx_tvalid),
        .tx_tready(tx_tready),
        .rx_level(rx_level),
        .tx_level(tx_level),
        .rx_word_cnt(rx_word_cnt),
        .tx_word_cnt(tx_word_cnt)
    );

    // Device/host model and stream collectors
    always @(posedge clk) begin
        if (!usb_rd_n && !usb_rxf_n) begin
            src_idx <= src_idx + 1;
            dir_q.push_back(1'b0);
        end
        if (!usb_wr_n && !txe_n) begin
            host_q.push_back(usb_data);
            dir_q.push_back(1'b1);
        end
        if (rx_tvalid && rx_tready)
            rx_q.push_back(rx_tdata);
    end

    always @(negedge clk) begin
        if (!usb_oe_n && !usb_wr_n)
            contention <= contention + 1;
        if (prev_oe_only && !(!usb_oe_n && !usb_rd_n))
            oe_err <= oe_err + 1;
        if (!usb_oe_n && usb_rd_n)
            oe_cnt <= oe_cnt + 1;
        prev_oe_only <= !usb_oe_n && usb_rd_n;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       valid;
        logic [7:0] base;
        int         reps;
        logic [4:0] exp_level;
        logic       exp_ready;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rx, base_host, base_dir, base_oe;
        tbl[0] = '{1'b0, 8'h00, 2,  5'd0,  1'b1};
        tbl[1] = '{1'b1, 8'h10, 1,  5'd1,  1'b1};
        tbl[2] = '{1'b0, 8'h00, 3,  5'd1,  1'b1};
        tbl[3] = '{1'b1, 8'h11, 14, 5'd15, 1'b1};
        tbl[4] = '{1'b1, 8'h1F, 1,  5'd16, 1'b0};
        tbl[5] = '{1'b1, 8'hEE, 3,  5'd16, 1'b0};

        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_oe_n", usb_oe_n, 1);
        chk("rst_rd_n", usb_rd_n, 1);
        chk("rst_wr_n", usb_wr_n, 1);
        chk("rst_rx_tvalid", rx_tvalid, 0);
        chk("rst_tx_tready", tx_tready, 1);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_cnt", rx_word_cnt, 0);
        chk("rst_tx_cnt", tx_word_cnt, 0);
        rst_n = 1'b1;
        tick();

        // TX fill table with the host not ready
        for (int v = 0; v < 6; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                tx_tvalid = tbl[v].valid;
                tx_tdata  = tbl[v].base + 8'(r);
                tick();
            end
            chk($sformatf("tbl%0d_tx_level", v), tx_level, tbl[v].exp_level);
            chk($sformatf("tbl%0d_tx_tready", v), tx_tready, tbl[v].exp_ready);
            chk($sformatf("tbl%0d_wr_n", v), usb_wr_n, 1);
        end
        tx_tvalid = 1'b0;

        // Drain the full TX buffer to the host
        txe_n = 1'b0;
        for (int i = 0; i < 300 && host_q.size() < 16; i++) tick();
        repeat (10) tick();
        chk("drain_host_words", host_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("drain_w%0d", i), host_q[i], 8'h10 + 8'(i));
        chk("drain_tx_level", tx_level, 0);
        chk("drain_tx_cnt", tx_word_cnt, 16);

        // 100-word read with consumer always ready
        rx_tready = 1'b1;
        base_rx = rx_q.size();
        base_oe = oe_cnt;
        for (int i = 0; i < 100; i++) src_mem[i] = 8'(i + 1);
        src_n = 100;
        rxf_block = 1'b0;
        for (int i = 0; i < 2000 && rx_q.size() < base_rx + 100; i++) tick();
        repeat (10) tick();
        chk("rd100_words", rx_q.size(), base_rx + 100);
        for (int i = 0; i < 100; i++)
            chk($sformatf("rd100_w%0d", i), rx_q[base_rx + i], 8'(i + 1));
        chk("rd100_rx_cnt", rx_word_cnt, 100);
        chk("rd100_rd_oe_cycles", oe_cnt - base_oe, 25);
        chk("rd100_rd_oe_single", oe_err, 0);

        // Consumer stalled: reading stops with the skid margin kept
        rx_tready = 1'b0;
        for (int i = 0; i < 30; i++) src_mem[100 + i] = 8'hA0 + 8'(i);
        src_n = 130;
        repeat (200) tick();
        chk("stall_rx_level", rx_level, 13);
        chk("stall_dev_idx", src_idx, 113);
        chk("stall_rx_cnt", rx_word_cnt, 113);
        base_rx = rx_q.size();
        rx_tready = 1'b1;
        for (int i = 0; i < 1000 && rx_q.size() < base_rx + 30; i++) tick();
        repeat (10) tick();
        chk("stall_words", rx_q.size(), base_rx + 30);
        for (int i = 0; i < 30; i++)
            chk($sformatf("stall_w%0d", i), rx_q[base_rx + i], 8'hA0 + 8'(i));
        chk("stall_rx_cnt_end", rx_word_cnt, 130);

        // 10 TX words with a one-cycle TXE# high pulse mid-burst
        txe_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tx_tvalid = 1'b1;
            tx_tdata  = 8'h60 + 8'(i);
            tick();
        end
        tx_tvalid = 1'b0;
        chk("tx10_level", tx_level, 10);
        base_host = host_q.size();
        txe_n = 1'b0;
        for (int i = 0; i < 20 && usb_wr_n; i++) tick();
        chk("tx10_wr_started", usb_wr_n, 0);
        tick(); tick();
        txe_n = 1'b1;
        tick();
        txe_n = 1'b0;
        for (int i = 0; i < 300 && host_q.size() < base_host + 10; i++) tick();
        repeat (10) tick();
        chk("tx10_words", host_q.size(), base_host + 10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("tx10_w%0d", i), host_q[base_host + i], 8'h60 + 8'(i));
        chk("tx10_tx_cnt", tx_word_cnt, 26);
        chk("tx10_tx_level", tx_level, 0);

        // Both directions ready: alternating 4-word bursts, read first
        txe_n = 1'b1;
        rxf_block = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tx_tvalid = 1'b1;
            tx_tdata  = 8'h40 + 8'(i);
            tick();
        end
        tx_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) src_mem[130 + i] = 8'h80 + 8'(i);
        src_n = 138;
        base_rx = rx_q.size();
        base_host = host_q.size();
        base_dir = dir_q.size();
        txe_n = 1'b0;
        rxf_block = 1'b0;
        for (int i = 0; i < 300 && dir_q.size() < base_dir + 16; i++) tick();
        repeat (10) tick();
        chk("arb_xfers", dir_q.size(), base_dir + 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("arb_dir%0d", i), dir_q[base_dir + i], (i / 4) % 2);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("arb_rx_w%0d", i), rx_q[base_rx + i], 8'h80 + 8'(i));
            chk($sformatf("arb_tx_w%0d", i), host_q[base_host + i], 8'h40 + 8'(i));
        end
        chk("arb_contention", contention, 0);

        // Asynchronous reset in the middle of a read burst
        rx_tready = 1'b0;
        rxf_block = 1'b1;
        for (int i = 0; i < 20; i++) src_mem[138 + i] = 8'hC0 + 8'(i);
        src_n = 158;
        rxf_block = 1'b0;
        for (int i = 0; i < 50 && usb_rd_n; i++) tick();
        chk("arst_rd_started", usb_rd_n, 0);
        tick();
        chk("arst_pre_level_nz", rx_level != 0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_rd_n", usb_rd_n, 1);
        chk("arst_oe_n", usb_oe_n, 1);
        chk("arst_wr_n", usb_wr_n, 1);
        rst_n = 1'b1;
        rxf_block = 1'b1;
        #1;
        chk("arst_rx_level", rx_level, 0);
        chk("arst_tx_level", tx_level, 0);
        chk("arst_rx_tvalid", rx_tvalid, 0);
        chk("arst_rx_cnt", rx_word_cnt, 0);
        chk("arst_tx_cnt", tx_word_cnt, 0);
        repeat (5) tick();
        chk("final_oe_err", oe_err, 0);
        chk("final_contention", contention, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
